// File: rtl/spram_banked_ctrl_if.sv
// Request/response bus of the banked single-port RAM controller.
// The master issues requests; the slave (the controller) returns read data.
interface spram_banked_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spram_banked_ctrl.sv
// Banked single-port RAM built from 16b x 16K SPRAM-style lanes.
// Byte-enable writes, valid/ready requests, 1-cycle read latency with a
// registered bank select, and an idle-driven standby/wake power FSM.
module spram_banked_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int BANK_BITS   = 1,
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  spram_banked_ctrl_if.slave   bus,
  input  logic                 sleep_en,
  output logic [1:0]           pwr_state
);

  localparam int LANES  = DATA_WIDTH / 16;
  localparam int BANKS  = 2 ** BANK_BITS;
  localparam int BSEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'b00,
    ST_STANDBY = 2'b01,
    ST_WAKE    = 2'b10
  } pwr_state_e;

  pwr_state_e        state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [BSEL_W-1:0] bank_q, bank_d;

  logic              accept;
  logic              standby_ok;
  logic              spram_standby;
  logic [BSEL_W-1:0] req_bank;
  logic [13:0]       row;
  logic [BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

  // Ready is forced low while reset is held, so nothing is accepted then.
  assign bus.req_ready  = (state_q == ST_ACTIVE) && !reset;
  assign accept         = bus.req_valid && bus.req_ready;
  assign spram_standby  = (state_q == ST_STANDBY);
  assign row            = bus.req_addr[13:0];
  assign pwr_state      = state_q;

  generate
    if (BANK_BITS > 0) begin : g_bank_sel
      assign req_bank = bus.req_addr[13+BANK_BITS:14];
    end else begin : g_single_bank
      assign req_bank = '0;
    end
  endgenerate

  // Standby is only entered from a quiet bus: no request and no response in flight.
  assign standby_ok = (IDLE_CYCLES != 0) && sleep_en && (idle_cnt_q == IDLE_MAX)
                      && !bus.req_valid && !rsp_valid_q;

  // Next-state logic for the power FSM, idle/wake counters and read response.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    rsp_valid_d = accept && !bus.req_we;
    bank_d      = accept ? req_bank : bank_q;
    case (state_q)
      ST_ACTIVE: begin
        if (accept) begin
          idle_cnt_d = '0;
        end else if (standby_ok) begin
          state_d = ST_STANDBY;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_STANDBY: begin
        if (bus.req_valid || !sleep_en) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        wake_cnt_d = wake_cnt_q + 1'b1;
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // Control state register; a reset mid-read drops the pending response at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACTIVE;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      bank_q      <= '0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      bank_q      <= bank_d;
    end
  end

  // One storage lane per 16 data bits per bank; nibble masks mirror MASKWREN.
  genvar gi, gj;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      logic chipselect;
      assign chipselect = accept && (req_bank == BSEL_W'(gi)) && !spram_standby;

      for (gj = 0; gj < LANES; gj++) begin : g_lane
        logic [15:0] mem [0:16383];
        logic [15:0] dout_q;
        logic [3:0]  maskwren;

        assign maskwren = {{2{bus.req_be[2*gj+1]}}, {2{bus.req_be[2*gj]}}};

        // Lane storage: masked write or registered read when selected.
        always_ff @(posedge clk) begin
          if (chipselect) begin
            if (bus.req_we) begin
              for (int n = 0; n < 4; n++) begin
                if (maskwren[n]) begin
                  mem[row][4*n +: 4] <= bus.req_wdata[16*gj + 4*n +: 4];
                end
              end
            end else begin
              dout_q <= mem[row];
            end
          end
        end

        assign bank_rdata[gi][16*gj +: 16] = dout_q;
      end
    end
  endgenerate

  // Read data is shown only during the response pulse.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_valid_q ? bank_rdata[bank_q] : '0;

endmodule

// File: tb/tb_spram_banked_ctrl.sv
// Self-checking bench for spram_banked_ctrl: directed table, hand-written
// power/reset sequences and a randomized run against a behavioural model.
module tb_spram_banked_ctrl;
  localparam int DW = 32, BB = 1, AW = 15, IDLE = 8, WAKE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sleep_en;
  logic [1:0] pwr_state, pwr_state0;

  always #5 clk = ~clk;

  spram_banked_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  spram_banked_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

  spram_banked_ctrl #(.DATA_WIDTH(DW), .BANK_BITS(BB), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .reset(reset), .bus(bus), .sleep_en(sleep_en), .pwr_state(pwr_state));

  // Second instance with standby disabled; it only ever sees an idle bus.
  spram_banked_ctrl #(.DATA_WIDTH(DW), .BANK_BITS(BB), .IDLE_CYCLES(0), .WAKE_CYCLES(WAKE)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .sleep_en(sleep_en), .pwr_state(pwr_state0));

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: word memory plus power mode (0 active, 1 standby, 2 wake).
  logic [31:0] m_mem [int];
  int          m_mode, m_idle, m_wake_cycles;
  bit          m_rv;
  logic [31:0] m_rd;

  typedef struct {
    bit          we;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [14];

  logic [14:0] pool [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idle = 0; m_wake_cycles = 0; m_rv = 0; m_rd = 0;
  endtask

  // Applies the rules for the request present at this clock edge.
  task automatic model_edge();
    bit acc, pend;
    int a;
    acc  = bus.req_valid && (m_mode == 0);
    pend = m_rv;
    a    = int'(bus.req_addr);
    m_rv = acc && !bus.req_we;
    m_rd = 0;
    if (m_rv) m_rd = m_mem.exists(a) ? m_mem[a] : 32'h0;
    if (acc && bus.req_we) begin
      if (!m_mem.exists(a)) m_mem[a] = 32'h0;
      for (int b = 0; b < 4; b++)
        if (bus.req_be[b]) m_mem[a][8*b +: 8] = bus.req_wdata[8*b +: 8];
    end
    if (m_mode == 0) begin
      if (acc) m_idle = 0;
      else if (IDLE > 0 && sleep_en && m_idle >= IDLE && !bus.req_valid && !pend) m_mode = 1;
      else if (m_idle < IDLE) m_idle++;
    end else if (m_mode == 1) begin
      if (bus.req_valid || !sleep_en) begin m_mode = 2; m_wake_cycles = 0; end
    end else begin
      m_wake_cycles++;
      if (m_wake_cycles == WAKE) begin m_mode = 0; m_idle = 0; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_rv});
    check("rsp_rdata", bus.rsp_rdata, m_rv ? m_rd : 32'h0);
    check("pwr_state", {30'b0, pwr_state}, m_mode);
    check("req_ready", {31'b0, bus.req_ready}, {31'b0, m_mode == 0});
    check("idle0_pwr_state", {30'b0, pwr_state0}, 32'h0);
  endtask

  task automatic set_req(input bit v, input bit we, input logic [14:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    bus.req_valid = v; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_be = be;
  endtask

  initial begin
    int cnt;
    tbl[0]  = '{1'b1, 15'h0005, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 15'h0005, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 15'h0010, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 15'h0010, 32'h00000000, 4'h5, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 15'h0010, 32'h0,        4'h0, 1'b1, 32'hFF00FF00};
    tbl[5]  = '{1'b1, 15'h0010, 32'h12345678, 4'h0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 15'h0010, 32'h0,        4'h0, 1'b1, 32'hFF00FF00};
    tbl[7]  = '{1'b1, 15'h0003, 32'h11111111, 4'hF, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 15'h4003, 32'h22222222, 4'hF, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 15'h0003, 32'h0,        4'h0, 1'b1, 32'h11111111};
    tbl[10] = '{1'b0, 15'h4003, 32'h0,        4'h0, 1'b1, 32'h22222222};
    tbl[11] = '{1'b0, 15'h0003, 32'h0,        4'h0, 1'b1, 32'h11111111};
    tbl[12] = '{1'b1, 15'h4007, 32'hAAAA5555, 4'hF, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 15'h4007, 32'h0,        4'h0, 1'b1, 32'hAAAA5555};
    pool = '{15'h0005, 15'h0010, 15'h0003, 15'h4003, 15'h4007, 15'h0003};

    reset = 1'b1; sleep_en = 1'b1;
    set_req(0, 0, '0, '0, '0);
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = '0;
    bus0.req_wdata = '0; bus0.req_be = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'h0);
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_pwr_state", {30'b0, pwr_state}, 32'h0);
    reset = 1'b0;
    #1;
    check("release_req_ready", {31'b0, bus.req_ready}, 32'h1);

    // Directed table, one request per cycle.
    for (int i = 0; i < 14; i++) begin
      set_req(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      step();
      check($sformatf("tbl%0d_rsp_valid", i), {31'b0, bus.rsp_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_rdata", i), bus.rsp_rdata, tbl[i].exp_rdata);
      $display("vec %0d: we=%0b addr=0x%04h rsp_valid=%0b rdata=0x%08h", i, tbl[i].we,
               tbl[i].addr, bus.rsp_valid, bus.rsp_rdata);
    end
    set_req(0, 0, '0, '0, '0);

    // Standby entry: counter reaches the threshold after IDLE idle edges, then one more edge to enter.
    cnt = 0;
    for (int i = 0; i < 40 && pwr_state != 2'b01; i++) begin step(); cnt++; end
    check("standby_entry_cycles", cnt, IDLE + 1);
    repeat (3) step();
    set_req(1, 0, 15'h0003, '0, '0);
    step();
    check("wake_entered", {30'b0, pwr_state}, 32'h2);
    cnt = 0;
    for (int i = 0; i < 20 && !bus.req_ready; i++) begin step(); cnt++; end
    check("wake_latency", cnt, WAKE);
    step();
    check("retained_rdata", bus.rsp_rdata, 32'h11111111);
    $display("standby/wake: latency=%0d rdata=0x%08h", cnt, bus.rsp_rdata);

    // Read presented on the idle-threshold cycle wins over standby entry.
    set_req(0, 0, '0, '0, '0);
    repeat (IDLE) step();
    set_req(1, 0, 15'h4003, '0, '0);
    step();
    check("thresh_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
    check("thresh_rdata", bus.rsp_rdata, 32'h22222222);
    check("thresh_pwr_state", {30'b0, pwr_state}, 32'h0);
    set_req(0, 0, '0, '0, '0);
    step();
    check("thresh_still_active", {30'b0, pwr_state}, 32'h0);
    $display("threshold read: rdata=0x22222222 checked, standby deferred");

    // Dropping sleep_en in standby wakes the RAM.
    for (int i = 0; i < 40 && pwr_state != 2'b01; i++) step();
    check("standby_again", {30'b0, pwr_state}, 32'h1);
    sleep_en = 1'b0;
    step();
    check("sleep_off_wake", {30'b0, pwr_state}, 32'h2);
    cnt = 0;
    for (int i = 0; i < 20 && !bus.req_ready; i++) begin step(); cnt++; end
    check("sleep_off_latency", cnt, WAKE);
    sleep_en = 1'b1;
    $display("sleep_en drop: wake latency=%0d", cnt);

    // Reset in the response cycle kills the response immediately.
    set_req(1, 0, 15'h0010, '0, '0);
    step();
    set_req(0, 0, '0, '0, '0);
    reset = 1'b1;
    #1;
    check("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) step();
    $display("reset mid-read: rsp_valid=%0b after release", bus.rsp_valid);

    // Randomized traffic over known addresses, honouring hold-until-accepted.
    for (int c = 0; c < 600; c++) begin
      if (!(bus.req_valid && m_mode != 0)) begin
        if ($urandom_range(0, 99) < 30)
          set_req(1, $urandom_range(0, 1) == 1, pool[$urandom_range(0, 5)], $urandom,
                  4'($urandom_range(0, 15)));
        else
          set_req(0, 0, '0, '0, '0);
        if ($urandom_range(0, 39) == 0) sleep_en = ~sleep_en;
      end
      if ($urandom_range(0, 49) == 0 && !bus.req_valid) begin
        repeat (12) step();
      end
      step();
      if (bus.rsp_valid)
        $display("rand %0d: rsp rdata=0x%08h model=0x%08h pwr=%0d", c, bus.rsp_rdata, m_rd, pwr_state);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
